// File: rtl/corescore_fmt_pkg.sv
// Shared types and ASCII helpers for the hex line formatter.
package corescore_fmt_pkg;

  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, CR, LF} fmt_state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // 0-9 -> '0'..'9'; 10-15 -> 'a'..'f' or 'A'..'F'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic uppercase);
    logic [7:0] base;
    if (nibble < 4'd10)  base = ASCII_ZERO;
    else if (uppercase)  base = 8'h37;
    else                 base = 8'h57;
    return base + 8'(nibble);
  endfunction

endpackage

// File: rtl/corescore_hex_nibble.sv
// Combinational nibble to ASCII hex digit.
module corescore_hex_nibble
  import corescore_fmt_pkg::*;
#(
  parameter bit UPPERCASE = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii_c
);

  assign ascii_c = nibble_to_ascii(nibble, UPPERCASE);

endmodule

// File: rtl/corescore_hex_formatter.sv
// Word to ASCII hex line ("0x", digits, CR, LF) streamed one byte per handshake.
// Build option CORESCORE_HEX_ZERO_SUPPRESS_EN skips leading zero digits.
module corescore_hex_formatter
  import corescore_fmt_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          PREFIX    = 1'b1,
  parameter bit          UPPERCASE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int unsigned NDIG = WIDTH / 4;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  fmt_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       data_d;
  logic             valid_d, ready_d;
  logic             word_xfer, byte_xfer;
  logic             skip_q, skip_d;
  logic [7:0]       digit_c;
`ifdef CORESCORE_HEX_ZERO_SUPPRESS_EN
  logic             seen_q, seen_d;
`endif

  // Digit for the byte about to be registered, taken from the next shift value
  corescore_hex_nibble #(.UPPERCASE(UPPERCASE)) u_nibble (
    .nibble  (shift_d[WIDTH-1 -: 4]),
    .ascii_c (digit_c)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= 8'h00;
`ifdef CORESCORE_HEX_ZERO_SUPPRESS_EN
      seen_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      o_ready <= ready_d;
      o_valid <= valid_d;
      o_data  <= data_d;
`ifdef CORESCORE_HEX_ZERO_SUPPRESS_EN
      seen_q  <= seen_d;
`endif
    end
  end

  // Next state, datapath and the registered output values for that next state
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = 8'h00;
    valid_d   = 1'b0;
    ready_d   = 1'b0;
    word_xfer = i_valid & o_ready;
    byte_xfer = o_valid & i_ready;
`ifdef CORESCORE_HEX_ZERO_SUPPRESS_EN
    seen_d    = seen_q;
    skip_q    = (state_q == DIGIT) && !seen_q && (cnt_q != '0) && (shift_q[WIDTH-1 -: 4] == 4'h0);
`else
    skip_q    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (word_xfer) begin
          shift_d = i_word;
          cnt_d   = CW'(NDIG - 1);
          state_d = PREFIX ? PFX0 : DIGIT;
`ifdef CORESCORE_HEX_ZERO_SUPPRESS_EN
          seen_d  = 1'b0;
`endif
        end
      end
      PFX0:  if (byte_xfer) state_d = PFX1;
      PFX1:  if (byte_xfer) state_d = DIGIT;
      DIGIT: begin
        // A bubble (skip_q) advances exactly like an emitted digit
        if (skip_q || byte_xfer) begin
          shift_d = shift_q << 4;
          if (cnt_q == '0) state_d = CR;
          else             cnt_d   = cnt_q - CW'(1);
`ifdef CORESCORE_HEX_ZERO_SUPPRESS_EN
          seen_d = seen_q | byte_xfer;
`endif
        end
      end
      CR:      if (byte_xfer) state_d = LF;
      LF:      if (byte_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef CORESCORE_HEX_ZERO_SUPPRESS_EN
    skip_d = (state_d == DIGIT) && !seen_d && (cnt_d != '0) && (shift_d[WIDTH-1 -: 4] == 4'h0);
`else
    skip_d = 1'b0;
`endif

    ready_d = (state_d == IDLE);
    valid_d = (state_d != IDLE) && !skip_d;
    case (state_d)
      PFX0:    data_d = ASCII_ZERO;
      PFX1:    data_d = ASCII_X;
      DIGIT:   data_d = digit_c;
      CR:      data_d = ASCII_CR;
      LF:      data_d = ASCII_LF;
      default: data_d = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_corescore_hex_formatter.sv
// Bench for corescore_hex_formatter: three configurations, byte scoreboard, table plus corner sequences.
module tb_corescore_hex_formatter;

`ifdef CORESCORE_HEX_ZERO_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_a [2];
  logic [7:0]  word_np;
  logic        val_a  [3];
  logic        irdy   [3];
  logic        ordy   [3];
  logic        oval   [3];
  logic [7:0]  odat   [3];
  logic        rnd_en;

  int total = 0;
  int bad   = 0;

  logic [7:0] expq [3][$];
  bit         prev_hold [3];
  logic [7:0] prev_data [3];
  bit         prev_rst;

  always #5 clk = ~clk;

  corescore_hex_formatter u_def (
    .i_clk(clk), .i_rst(rst), .i_word(word_a[0]), .i_valid(val_a[0]),
    .o_ready(ordy[0]), .o_data(odat[0]), .o_valid(oval[0]), .i_ready(irdy[0]));

  corescore_hex_formatter #(.UPPERCASE(1'b1)) u_up (
    .i_clk(clk), .i_rst(rst), .i_word(word_a[1]), .i_valid(val_a[1]),
    .o_ready(ordy[1]), .o_data(odat[1]), .o_valid(oval[1]), .i_ready(irdy[1]));

  corescore_hex_formatter #(.WIDTH(8), .PREFIX(1'b0)) u_np (
    .i_clk(clk), .i_rst(rst), .i_word(word_np), .i_valid(val_a[2]),
    .o_ready(ordy[2]), .o_data(odat[2]), .o_valid(oval[2]), .i_ready(irdy[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input int d, input string s);
    for (int i = 0; i < s.len(); i++) expq[d].push_back(s[i]);
    expq[d].push_back(8'h0D);
    expq[d].push_back(8'h0A);
  endtask

  task automatic set_word(input int d, input logic [31:0] w);
    if (d == 2) word_np = w[7:0];
    else        word_a[d] = w;
  endtask

  // Wait (bounded) until the DUT is ready, then let the word transfer on the next edge
  task automatic wait_accept(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ordy[d] && n < 200);
    if (!ordy[d]) begin
      total++; bad++;
      $display("FAIL accept_timeout dut%0d: got ready=0 want ready=1", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int d, input logic [31:0] w, input string s,
                           output int cyc, output int nval, output logic first_val);
    tick();
    push_line(d, s);
    set_word(d, w);
    val_a[d] = 1'b1;
    wait_accept(d);
    val_a[d] = 1'b0;
    cyc = 0; nval = 0; first_val = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) first_val = oval[d];
      if (ordy[d]) break;
      if (oval[d]) nval++;
      if (cyc > 2000) begin
        total++; bad++;
        $display("FAIL line_timeout dut%0d: got no idle want idle", d);
        break;
      end
    end
    chk($sformatf("queue_empty dut%0d", d), expq[d].size(), 0);
  endtask

  // Byte scoreboard and hold-stability monitor
  always @(negedge clk) begin
    logic [7:0] e;
    for (int k = 0; k < 3; k++) begin
      if (prev_hold[k] && prev_rst) begin
        chk($sformatf("hold_valid dut%0d", k), 32'(oval[k]), 32'd1);
        chk($sformatf("hold_data dut%0d", k), 32'(odat[k]), 32'(prev_data[k]));
      end
      if (rst && oval[k] && irdy[k]) begin
        if (expq[k].size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte dut%0d: got %0h want none", k, odat[k]);
        end else begin
          e = expq[k].pop_front();
          chk($sformatf("byte dut%0d", k), 32'(odat[k]), 32'(e));
        end
      end
      prev_hold[k] = oval[k] & ~irdy[k];
      prev_data[k] = odat[k];
    end
    prev_rst = rst;
  end

  // Emitter ready: held high, or pseudo-random when rnd_en
  initial begin
    for (int k = 0; k < 3; k++) irdy[k] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) irdy[k] = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          dut;
    logic [31:0] word;
    string       exp;
    bit          rnd;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int cyc, nval, n;
    logic fv;

    tbl.push_back('{0, 32'hDEADBEEF, "0xdeadbeef", 1'b0});
    tbl.push_back('{0, 32'hDEADBEEF, "0xdeadbeef", 1'b1});
    tbl.push_back('{0, 32'h0000012A, ZS ? "0x12a" : "0x0000012a", 1'b0});
    tbl.push_back('{0, 32'h00000000, ZS ? "0x0" : "0x00000000", 1'b0});
    tbl.push_back('{0, 32'hF000000F, "0xf000000f", 1'b1});
    tbl.push_back('{1, 32'h0000012A, ZS ? "0x12A" : "0x0000012A", 1'b0});
    tbl.push_back('{1, 32'hABCDEF90, "0xABCDEF90", 1'b0});
    tbl.push_back('{2, 32'h0000005C, "5c", 1'b0});
    tbl.push_back('{2, 32'h00000000, ZS ? "0" : "00", 1'b0});
    tbl.push_back('{2, 32'h0000000A, ZS ? "a" : "0a", 1'b0});
    tbl.push_back('{2, 32'h000000F0, "f0", 1'b1});

    rnd_en = 1'b0;
    rst = 1'b0;
    word_a[0] = '0; word_a[1] = '0; word_np = '0;
    for (int k = 0; k < 3; k++) val_a[k] = 1'b0;

    // Reset values, then o_ready rises one edge after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready dut%0d", k), 32'(ordy[k]), 32'd0);
      chk($sformatf("rst_valid dut%0d", k), 32'(oval[k]), 32'd0);
      chk($sformatf("rst_data dut%0d", k), 32'(odat[k]), 32'd0);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("ready_before_release_edge", 32'(ordy[0]), 32'd0);
    @(negedge clk);
    chk("ready_after_release_edge", 32'(ordy[0]), 32'd1);

    foreach (tbl[i]) begin
      rnd_en = tbl[i].rnd;
      send_line(tbl[i].dut, tbl[i].word, tbl[i].exp, cyc, nval, fv);
      rnd_en = 1'b0;
    end

    // Full-rate timing: 12 bytes on consecutive cycles, first right after acceptance
    send_line(0, 32'hDEADBEEF, "0xdeadbeef", cyc, nval, fv);
    chk("first_byte_latency", 32'(fv), 32'd1);
    chk("line_cycles", 32'(cyc), 32'd13);
    chk("line_valid_cycles", 32'(nval), 32'd12);

    // Leading-zero bubbles on the uppercase instance
    send_line(1, 32'h0000012A, ZS ? "0x12A" : "0x0000012A", cyc, nval, fv);
    chk("zs_valid_cycles", 32'(nval), ZS ? 32'd7 : 32'd12);
    chk("zs_bubbles", 32'(cyc - 1 - nval), ZS ? 32'd5 : 32'd0);

    // i_valid held high across two words: second accepted one cycle after LF
    tick();
    push_line(0, ZS ? "0x1" : "0x00000001");
    push_line(0, ZS ? "0x2" : "0x00000002");
    word_a[0] = 32'h1;
    val_a[0] = 1'b1;
    wait_accept(0);
    word_a[0] = 32'h2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ordy[0] && n < 100);
    chk("b2b_gap", 32'(n), 32'd13);
    @(posedge clk);
    #1;
    val_a[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ordy[0] && n < 100);
    chk("b2b_second_len", 32'(n), 32'd13);
    chk("b2b_queue_empty", expq[0].size(), 0);

    // Reset while the third digit is presented
    tick();
    expq[0].push_back(8'h30); expq[0].push_back(8'h78);
    expq[0].push_back(8'h64); expq[0].push_back(8'h65);
    word_a[0] = 32'hDEADBEEF;
    val_a[0] = 1'b1;
    wait_accept(0);
    val_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("third_digit_shown", 32'(odat[0]), 32'h61);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midline_rst_ready", 32'(ordy[0]), 32'd0);
    chk("midline_rst_valid", 32'(oval[0]), 32'd0);
    chk("midline_rst_data", 32'(odat[0]), 32'd0);
    chk("midline_queue", expq[0].size(), 0);
    tick();
    rst = 1'b1;
    send_line(0, 32'hDEADBEEF, "0xdeadbeef", cyc, nval, fv);
    chk("fresh_line_valid_cycles", 32'(nval), 32'd12);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
